// File: rtl/snake_pkg.sv
// snake_pkg: shared state/direction codes, grid defaults and wrap-around stepping for the snake game
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam int GRID_X_DEF = 160;
    localparam int GRID_Y_DEF = 120;

    // One step along an axis of length max+1, wrapping by comparison with the limit.
    function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic inc, input logic [7:0] max);
        return inc ? ((v == max) ? 8'd0 : v + 8'd1) : ((v == 8'd0) ? max : v - 8'd1);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: modulo-TICK_DIV counter producing a one-cycle tick, held at zero while disabled
module snake_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CW'(TICK_DIV - 1));
    assign cnt_d  = (!en_i || tick_o) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i) cnt_q <= reset_i ? '0 : cnt_d;

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-state sequencer for the snake game; schedules move ticks,
// advances the head with wrap-around, detects target capture and keeps the score.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 25_000_000,
    parameter int GRID_X    = GRID_X_DEF,
    parameter int GRID_Y    = GRID_Y_DEF,
    parameter int WIN_SCORE = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btnu_i,
    input  logic       btnr_i,
    input  logic       btnd_i,
    input  logic       btnl_i,
    input  logic [1:0] dir_i,
    input  logic [7:0] target_x_i,
    input  logic [6:0] target_y_i,
    input  logic       self_hit_i,
    output logic [1:0] state_o,
    output logic       move_tick_o,
    output logic [7:0] head_x_o,
    output logic [6:0] head_y_o,
    output logic       target_reached_o,
    output logic [3:0] score_o
);

    localparam logic [7:0] X_MAX = 8'(GRID_X - 1);
    localparam logic [7:0] Y_MAX = 8'(GRID_Y - 1);
    localparam logic [7:0] X0    = 8'(GRID_X / 2);
    localparam logic [6:0] Y0    = 7'(GRID_Y / 2);
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);

    state_e     state_q, state_d;
    logic [7:0] head_x_q, head_x_d, next_x;
    logic [6:0] head_y_q, head_y_d, next_y;
    logic [3:0] score_q, score_d;
    logic       move_tick_q, move_tick_d;
    logic       reached_q, reached_d;
    logic       any, any_q, start, tick, hit;
    dir_e       dir;

    assign any    = btnu_i | btnr_i | btnd_i | btnl_i;
    assign start  = any & ~any_q;
    assign dir    = dir_e'(dir_i);
    assign hit    = (head_x_q == target_x_i) && (head_y_q == target_y_i);
    assign next_x = (dir == DIR_RIGHT || dir == DIR_LEFT) ? wrap_step(head_x_q, dir == DIR_RIGHT, X_MAX) : head_x_q;
    assign next_y = (dir == DIR_UP || dir == DIR_DOWN) ? 7'(wrap_step({1'b0, head_y_q}, dir == DIR_DOWN, Y_MAX)) : head_y_q;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (state_q == ST_PLAY),
        .tick_o (tick)
    );

    // Keeps tracking through reset so a button held across reset cannot start a game.
    always_ff @(posedge clk_i) any_q <= any;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            head_x_q    <= X0;
            head_y_q    <= Y0;
            score_q     <= '0;
            move_tick_q <= 1'b0;
            reached_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            score_q     <= score_d;
            move_tick_q <= move_tick_d;
            reached_q   <= reached_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        score_d     = score_q;
        move_tick_d = 1'b0;
        reached_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_PLAY;
                head_x_d = X0;
                head_y_d = Y0;
                score_d  = '0;
            end
            ST_PLAY: begin
                move_tick_d = tick;
                head_x_d    = tick ? next_x : head_x_q;
                head_y_d    = tick ? next_y : head_y_q;
                // Capture is judged against the head already moved on the previous tick edge.
                if (move_tick_q && self_hit_i) begin
                    state_d = ST_LOSE;
                end else if (move_tick_q && hit) begin
                    reached_d = 1'b1;
                    score_d   = score_q + 4'd1;
                    state_d   = (score_q + 4'd1 == WIN) ? ST_WIN : ST_PLAY;
                end
            end
            default: if (start) state_d = ST_IDLE;
        endcase
    end

    assign state_o          = state_q;
    assign move_tick_o      = move_tick_q;
    assign head_x_o         = head_x_q;
    assign head_y_o         = head_y_q;
    assign target_reached_o = reached_q;
    assign score_o          = score_q;

endmodule
